// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store MEM stage: FSM states,
// access-size encodings and exception codes.
package lsu_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ0 = 3'd1,
        RSP0 = 3'd2,
        REQ1 = 3'd3,
        RSP1 = 3'd4,
        DONE = 3'd5
    } lsu_state_t;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    localparam logic [1:0] EXC_NONE = 2'b00;
    localparam logic [1:0] EXC_MIS  = 2'b01;
    localparam logic [1:0] EXC_BUS  = 2'b10;

    // funct3[1:0] of 10 and 11 both mean a full word.
    function automatic logic [1:0] size_of(input logic [2:0] funct3);
        return funct3[1] ? SZ_W : funct3[1:0];
    endfunction

endpackage

// File: rtl/lsu_mem_stage_align.sv
// Combinational lane alignment: byte masks and shifted store data for both
// beats, misalignment detection, and extraction/extension of load data.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]  k,
    input  logic [1:0]  size,
    input  logic        zext,
    input  logic [31:0] r2,
    input  logic [31:0] rdata0,
    input  logic [31:0] rdata1,
    output logic        misaligned,
    output logic [3:0]  mask0,
    output logic [3:0]  mask1,
    output logic [31:0] wdata0,
    output logic [31:0] wdata1,
    output logic [31:0] load_data
);

    logic [3:0]  base;
    logic [7:0]  span;
    logic [5:0]  sh;
    logic [63:0] wide_w;
    logic [63:0] wide_r;

    always_comb begin
        base       = 4'b0001;
        misaligned = 1'b0;
        case (size)
            SZ_B: begin
                base       = 4'b0001;
                misaligned = 1'b0;
            end
            SZ_H: begin
                base       = 4'b0011;
                misaligned = (k == 2'd3);
            end
            default: begin
                base       = 4'b1111;
                misaligned = (k != 2'd0);
            end
        endcase

        // An 8-lane window covers both beats; the upper half spills into beat 1.
        sh     = {1'b0, k, 3'b000};
        span   = {4'b0000, base} << k;
        mask0  = span[3:0];
        mask1  = span[7:4];

        wide_w = {32'h0, r2} << sh;
        wdata0 = wide_w[31:0];
        wdata1 = wide_w[63:32];

        wide_r = {rdata1, rdata0} >> sh;
        case (size)
            SZ_B:    load_data = {{24{~zext & wide_r[7]}}, wide_r[7:0]};
            SZ_H:    load_data = {{16{~zext & wide_r[15]}}, wide_r[15:0]};
            default: load_data = wide_r[31:0];
        endcase
    end

endmodule

// File: rtl/lsu_mem_stage.sv
// MEM stage with a variable-latency req/gnt/rvalid data-memory port, optional
// two-beat misaligned accesses, a bus timeout and the MEM/WB register.
module lsu_mem_stage
    import lsu_pkg::*;
#(
    parameter int AW               = 32,
    parameter bit SPLIT_MISALIGNED = 1'b1,
    parameter int TIMEOUT          = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [2:0]    strCtrlM,
    input  logic          MemWriteM,
    input  logic          MemtoRegM,
    input  logic          RegWriteM,
    input  logic [31:0]   ALUoutM,
    input  logic [31:0]   r2M,
    input  logic [4:0]    rdM,
    output logic          stallM,
    output logic          dmem_req,
    output logic          dmem_we,
    output logic [AW-1:0] dmem_addr,
    output logic [3:0]    dmem_wmask,
    output logic [31:0]   dmem_wdata,
    input  logic          dmem_gnt,
    input  logic          dmem_rvalid,
    input  logic [31:0]   dmem_rdata,
    output logic [31:0]   ALUoutW,
    output logic [31:0]   ReadDataW,
    output logic [4:0]    rdW,
    output logic          MemtoRegW,
    output logic          RegWriteW,
    output logic [1:0]    ExcW
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int CW = (TW > 0) ? TW : 1;
    // The timer fires when the cycle about to end is the TIMEOUT-th in this state.
    localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT - 1);

    lsu_state_t    state;
    lsu_state_t    state_n;
    logic [CW-1:0] tmr;
    logic [1:0]    exc_q;
    logic [1:0]    exc_n;
    logic [31:0]   rdata0_q;
    logic [31:0]   rdata1_q;

    logic          is_mem;
    logic          timing;
    logic          tmo_hit;
    logic          split;
    logic          misaligned;
    logic [3:0]    mask0;
    logic [3:0]    mask1;
    logic [31:0]   wdata0;
    logic [31:0]   wdata1;
    logic [31:0]   load_data;
    logic [AW-1:0] beat0_addr;
    logic [AW-1:0] beat1_addr;

    lsu_align u_align (
        .k          (ALUoutM[1:0]),
        .size       (size_of(strCtrlM)),
        .zext       (strCtrlM[2]),
        .r2         (r2M),
        .rdata0     (rdata0_q),
        .rdata1     (rdata1_q),
        .misaligned (misaligned),
        .mask0      (mask0),
        .mask1      (mask1),
        .wdata0     (wdata0),
        .wdata1     (wdata1),
        .load_data  (load_data)
    );

    assign is_mem     = MemWriteM | MemtoRegM;
    assign split      = SPLIT_MISALIGNED & misaligned;
    assign beat0_addr = {ALUoutM[AW-1:2], 2'b00};
    assign beat1_addr = beat0_addr + AW'(4);
    assign timing     = (state == REQ0) || (state == RSP0) ||
                        (state == REQ1) || (state == RSP1);
    assign tmo_hit    = (TIMEOUT != 0) && (tmr == TMO_LAST);

    // Bus fields: beat 1 only differs in address, mask and data lanes.
    always_comb begin
        dmem_we    = MemWriteM;
        dmem_addr  = beat0_addr;
        dmem_wmask = mask0;
        dmem_wdata = wdata0;
        if (state == REQ1) begin
            dmem_addr  = beat1_addr;
            dmem_wmask = mask1;
            dmem_wdata = wdata1;
        end
    end

    always_comb begin
        state_n  = state;
        exc_n    = exc_q;
        stallM   = 1'b0;
        dmem_req = 1'b0;
        case (state)
            IDLE: begin
                if (is_mem) begin
                    stallM = 1'b1;
                    if (misaligned && !SPLIT_MISALIGNED) begin
                        state_n = DONE;
                        exc_n   = EXC_MIS;
                    end else begin
                        state_n = REQ0;
                        exc_n   = EXC_NONE;
                    end
                end
            end
            REQ0, REQ1: begin
                stallM   = 1'b1;
                dmem_req = 1'b1;
                if (dmem_gnt) begin
                    state_n = (state == REQ0) ? RSP0 : RSP1;
                end else if (tmo_hit) begin
                    state_n = DONE;
                    exc_n   = EXC_BUS;
                end
            end
            RSP0, RSP1: begin
                stallM = 1'b1;
                if (dmem_rvalid) begin
                    state_n = (state == RSP0 && split) ? REQ1 : DONE;
                end else if (tmo_hit) begin
                    state_n = DONE;
                    exc_n   = EXC_BUS;
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            tmr      <= '0;
            exc_q    <= EXC_NONE;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            state <= state_n;
            exc_q <= exc_n;
            if (state_n != state) begin
                tmr <= '0;
            end else if (timing && TIMEOUT != 0) begin
                tmr <= tmr + CW'(1);
            end
            // Clearing in IDLE makes the upper word zero for single-beat loads.
            if (state == IDLE) begin
                rdata0_q <= '0;
                rdata1_q <= '0;
            end
            if (state == RSP0 && dmem_rvalid) begin
                rdata0_q <= dmem_rdata;
            end
            if (state == RSP1 && dmem_rvalid) begin
                rdata1_q <= dmem_rdata;
            end
        end
    end

    // MEM/WB register: result in DONE, bubble while stalled, pass-through otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            ALUoutW   <= '0;
            ReadDataW <= '0;
            rdW       <= '0;
            MemtoRegW <= 1'b0;
            RegWriteW <= 1'b0;
            ExcW      <= EXC_NONE;
        end else if (state == DONE) begin
            ALUoutW   <= ALUoutM;
            rdW       <= rdM;
            MemtoRegW <= MemtoRegM;
            RegWriteW <= RegWriteM && (exc_q == EXC_NONE);
            ExcW      <= exc_q;
            ReadDataW <= (MemtoRegM && exc_q == EXC_NONE) ? load_data : '0;
        end else if (stallM) begin
            ALUoutW   <= '0;
            ReadDataW <= '0;
            rdW       <= '0;
            MemtoRegW <= 1'b0;
            RegWriteW <= 1'b0;
            ExcW      <= EXC_NONE;
        end else begin
            ALUoutW   <= ALUoutM;
            ReadDataW <= '0;
            rdW       <= rdM;
            MemtoRegW <= MemtoRegM;
            RegWriteW <= RegWriteM;
            ExcW      <= EXC_NONE;
        end
    end

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Bench for lsu_mem_stage: directed cases plus random loads/stores against a
// byte-level memory model, on a split/timeout instance and a flag-only instance.
module tb_lsu_mem_stage;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, rst2;
    logic [2:0]  strCtrlM;
    logic        MemWriteM, MemtoRegM, RegWriteM;
    logic [31:0] ALUoutM, r2M;
    logic [4:0]  rdM;

    logic        stallM, dmem_req, dmem_we, dmem_gnt, dmem_rvalid;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_wmask;
    logic [31:0] ALUoutW, ReadDataW;
    logic [4:0]  rdW;
    logic        MemtoRegW, RegWriteW;
    logic [1:0]  ExcW;

    logic        ns_stallM, ns_req, ns_we, ns_gnt;
    logic        ns_rvalid = 1'b0;
    logic [31:0] ns_addr, ns_wdata, ns_rdata;
    logic [3:0]  ns_wmask;
    logic [31:0] ns_ALUoutW, ns_ReadDataW;
    logic [4:0]  ns_rdW;
    logic        ns_MemtoRegW, ns_RegWriteW;
    logic [1:0]  ns_ExcW;

    lsu_mem_stage #(.AW(32), .SPLIT_MISALIGNED(1'b1), .TIMEOUT(8)) dut (
        .clk(clk), .rst(rst), .strCtrlM(strCtrlM), .MemWriteM(MemWriteM),
        .MemtoRegM(MemtoRegM), .RegWriteM(RegWriteM), .ALUoutM(ALUoutM), .r2M(r2M),
        .rdM(rdM), .stallM(stallM), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_wmask(dmem_wmask), .dmem_wdata(dmem_wdata),
        .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
        .ALUoutW(ALUoutW), .ReadDataW(ReadDataW), .rdW(rdW), .MemtoRegW(MemtoRegW),
        .RegWriteW(RegWriteW), .ExcW(ExcW)
    );

    lsu_mem_stage #(.AW(32), .SPLIT_MISALIGNED(1'b0), .TIMEOUT(0)) dut_ns (
        .clk(clk), .rst(rst2), .strCtrlM(strCtrlM), .MemWriteM(MemWriteM),
        .MemtoRegM(MemtoRegM), .RegWriteM(RegWriteM), .ALUoutM(ALUoutM), .r2M(r2M),
        .rdM(rdM), .stallM(ns_stallM), .dmem_req(ns_req), .dmem_we(ns_we),
        .dmem_addr(ns_addr), .dmem_wmask(ns_wmask), .dmem_wdata(ns_wdata),
        .dmem_gnt(ns_gnt), .dmem_rvalid(ns_rvalid), .dmem_rdata(ns_rdata),
        .ALUoutW(ns_ALUoutW), .ReadDataW(ns_ReadDataW), .rdW(ns_rdW),
        .MemtoRegW(ns_MemtoRegW), .RegWriteW(ns_RegWriteW), .ExcW(ns_ExcW)
    );

    // Second instance: always granted, responds exactly one cycle after the grant.
    always @(posedge clk) ns_rvalid <= ns_req & ns_gnt;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    // Memory model: bus view (word, written through the DUT's masks) and reference view (byte).
    logic [31:0] bus_mem [logic [31:0]];
    logic [7:0]  ref_mem [logic [31:0]];

    function automatic logic [7:0] init_byte(input logic [31:0] a);
        return a[7:0] ^ {a[11:8], a[15:12]} ^ 8'hA5;
    endfunction

    function automatic logic [7:0] ref_rd(input logic [31:0] a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return init_byte(a);
    endfunction

    function automatic logic [31:0] bus_rd(input logic [31:0] wa);
        if (bus_mem.exists(wa)) return bus_mem[wa];
        return {init_byte(wa + 32'd3), init_byte(wa + 32'd2), init_byte(wa + 32'd1), init_byte(wa)};
    endfunction

    task automatic bus_wr(input logic [31:0] wa, input logic [3:0] m, input logic [31:0] d);
        logic [31:0] w;
        w = bus_rd(wa);
        for (int l = 0; l < 4; l++) if (m[l]) w[8*l +: 8] = d[8*l +: 8];
        bus_mem[wa] = w;
    endtask

    task automatic poke_word(input logic [31:0] wa, input logic [31:0] d);
        bus_mem[wa] = d;
        for (int l = 0; l < 4; l++) ref_mem[wa + 32'(l)] = d[8*l +: 8];
    endtask

    function automatic int nbytes(input logic [2:0] f3);
        return f3[1] ? 4 : (f3[0] ? 2 : 1);
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a);
        int n;
        logic [31:0] v;
        n = nbytes(f3);
        v = '0;
        for (int i = 0; i < n; i++) v[8*i +: 8] = ref_rd(a + 32'(i));
        if (!f3[2] && n == 1 && v[7])  v[31:8]  = '1;
        if (!f3[2] && n == 2 && v[15]) v[31:16] = '1;
        return v;
    endfunction

    function automatic int pick(input int fix);
        if (fix < 0) return int'($urandom_range(0, 3));
        return fix;
    endfunction

    logic [31:0] last_addr [2];
    logic [3:0]  last_mask [2];
    logic [31:0] last_wdata [2];
    int          last_stall;

    // Drives one M-stage op on the main instance, acts as the memory, then checks W.
    task automatic run_op(input logic [2:0] f3, input logic wr, input logic ld, input logic rw,
                          input logic [31:0] a, input logic [31:0] d, input logic [4:0] rd,
                          input int gfix, input int rfix, input bit hang);
        int gwait, g_used, rwait, stall_cnt, exp_stall, nb, exp_nb, n, off;
        bit pend, done, memop;
        logic [31:0] rsp_data, exp_ld;
        logic [3:0]  exp_mask [2];
        logic [1:0]  exp_exc;
        memop   = wr | ld;
        n       = nbytes(f3);
        exp_ld  = ref_load(f3, a);
        exp_exc = hang ? 2'b10 : 2'b00;
        exp_nb  = !memop ? 0 : (hang ? 1 : ((int'(a[1:0]) + n > 4) ? 2 : 1));
        exp_mask[0] = 4'b0000;
        exp_mask[1] = 4'b0000;
        for (int i = 0; i < n; i++) begin
            off = int'(a[1:0]) + i;
            exp_mask[off / 4][off % 4] = 1'b1;
        end
        strCtrlM = f3; MemWriteM = wr; MemtoRegM = ld; RegWriteM = rw;
        ALUoutM = a; r2M = d; rdM = rd;
        gwait = pick(gfix); g_used = gwait; rwait = 0;
        pend = 0; done = 0; stall_cnt = 0; nb = 0; rsp_data = '0;
        exp_stall = memop ? 1 : 0;
        for (int cyc = 0; cyc < 40 && !done; cyc++) begin
            @(negedge clk);
            dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = $urandom;
            if (!stallM) begin
                done = 1;
                if (memop) chk("req_low_on_completion", {31'b0, dmem_req}, 32'd0);
            end else begin
                stall_cnt++;
                if (pend) begin
                    if (rwait == 0 && !hang) begin
                        dmem_rvalid = 1'b1; dmem_rdata = rsp_data; pend = 0;
                        gwait = pick(gfix); g_used = gwait;
                    end else if (rwait > 0) begin
                        rwait--;
                    end
                end else if (dmem_req) begin
                    if (gwait == 0) begin
                        dmem_gnt = 1'b1;
                        if (nb < 2) begin
                            last_addr[nb] = dmem_addr; last_mask[nb] = dmem_wmask;
                            last_wdata[nb] = dmem_wdata;
                            chk("beat_we", {31'b0, dmem_we}, {31'b0, wr});
                        end
                        nb++;
                        rsp_data = bus_rd(dmem_addr);
                        if (dmem_we) bus_wr(dmem_addr, dmem_wmask, dmem_wdata);
                        rwait = pick(rfix); pend = 1;
                        exp_stall += (g_used + 1) + (hang ? 8 : rwait + 1);
                    end else begin
                        gwait--;
                    end
                end
            end
            @(posedge clk);
        end
        #1;
        dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
        last_stall = stall_cnt;
        chk("op_completed", {31'b0, done}, 32'd1);
        chk("stall_cycles", stall_cnt, exp_stall);
        chk("beat_count", nb, exp_nb);
        for (int b = 0; b < 2; b++) begin
            if (b < nb && b < exp_nb) begin
                chk("beat_addr", last_addr[b], {a[31:2], 2'b00} + 32'(4 * b));
                if (wr) chk("beat_mask", {28'b0, last_mask[b]}, {28'b0, exp_mask[b]});
            end
        end
        chk("ALUoutW", ALUoutW, a);
        chk("rdW", {27'b0, rdW}, {27'b0, rd});
        chk("MemtoRegW", {31'b0, MemtoRegW}, {31'b0, ld});
        chk("ExcW", {30'b0, ExcW}, {30'b0, exp_exc});
        chk("RegWriteW", {31'b0, RegWriteW}, {31'b0, rw & ~hang});
        if (memop) chk("ReadDataW", ReadDataW, (ld && !hang) ? exp_ld : 32'd0);
        if (wr && !hang) begin
            for (int i = 0; i < n; i++) ref_mem[a + 32'(i)] = d[8*i +: 8];
            for (int i = -1; i <= 4; i++) begin
                logic [31:0] ba, w;
                ba = a + 32'(i);
                w  = bus_rd({ba[31:2], 2'b00});
                chk("mem_byte", {24'b0, w[8*ba[1:0] +: 8]}, {24'b0, ref_rd(ba)});
            end
        end
    endtask

    // Drives one op on the flag-only instance; counts stalled cycles and requests.
    task automatic run_ns(input logic [2:0] f3, input logic wr, input logic ld,
                          input logic [31:0] a, output int stalls, output int reqs);
        bit done;
        strCtrlM = f3; MemWriteM = wr; MemtoRegM = ld; RegWriteM = 1'b1;
        ALUoutM = a; r2M = $urandom; rdM = 5'd7;
        stalls = 0; reqs = 0; done = 0;
        for (int cyc = 0; cyc < 20 && !done; cyc++) begin
            @(negedge clk);
            if (ns_req) reqs++;
            if (ns_stallM) stalls++;
            else done = 1;
            @(posedge clk);
        end
        #1;
        chk("ns_completed", {31'b0, done}, 32'd1);
    endtask

    task automatic set_nop();
        strCtrlM = 3'b000; MemWriteM = 1'b0; MemtoRegM = 1'b0; RegWriteM = 1'b0;
        ALUoutM = '0; r2M = '0; rdM = '0;
    endtask

    logic [2:0] ld_f3 [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

    initial begin
        int st, rq, kind;
        bit seen;
        logic [31:0] ra;
        rst = 1'b1; rst2 = 1'b1;
        dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;
        ns_gnt = 1'b1; ns_rdata = 32'hDEADBEEF;
        set_nop();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_stallM", {31'b0, stallM}, 32'd0);
        chk("rst_dmem_req", {31'b0, dmem_req}, 32'd0);
        chk("rst_W", {ALUoutW[15:0], 3'b0, rdW, 5'b0, MemtoRegW, RegWriteW, ExcW[0]} | {ALUoutW[31:16], 15'b0, ExcW[1]}, 32'd0);
        chk("rst_ReadDataW", ReadDataW, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Non-memory op passes straight through.
        run_op(3'b000, 1'b0, 1'b0, 1'b1, 32'h1234, 32'h0, 5'd5, -1, -1, 1'b0);
        chk("nop_stall_never", last_stall, 0);

        // LB / LBU at 0x103, immediate grant, response two cycles after grant.
        poke_word(32'h100, 32'h80FFFFFF);
        run_op(3'b000, 1'b0, 1'b1, 1'b1, 32'h103, 32'h0, 5'd3, 0, 1, 1'b0);
        chk("lb_value", ReadDataW, 32'hFFFFFF80);
        chk("lb_stall4", last_stall, 4);
        run_op(3'b100, 1'b0, 1'b1, 1'b1, 32'h103, 32'h0, 5'd3, 0, 1, 1'b0);
        chk("lbu_value", ReadDataW, 32'h00000080);
        chk("lbu_stall4", last_stall, 4);

        // Split word store at 0x202.
        run_op(3'b010, 1'b1, 1'b0, 1'b0, 32'h202, 32'hAABBCCDD, 5'd0, 0, 0, 1'b0);
        chk("sw_b0_addr", last_addr[0], 32'h200);
        chk("sw_b0_mask", {28'b0, last_mask[0]}, 32'hC);
        chk("sw_b0_data", {16'b0, last_wdata[0][31:16]}, 32'hCCDD);
        chk("sw_b1_addr", last_addr[1], 32'h204);
        chk("sw_b1_mask", {28'b0, last_mask[1]}, 32'h3);
        chk("sw_b1_data", {16'b0, last_wdata[1][15:0]}, 32'hAABB);

        // Split word load across the top of the address space.
        poke_word(32'hFFFFFFFC, 32'h11220000);
        poke_word(32'h00000000, 32'h00003344);
        run_op(3'b010, 1'b0, 1'b1, 1'b1, 32'hFFFFFFFE, 32'h0, 5'd8, -1, -1, 1'b0);
        chk("lw_wrap_b1_addr", last_addr[1], 32'h0);
        chk("lw_wrap_value", ReadDataW, 32'h33441122);

        // Granted load that never gets a response.
        run_op(3'b010, 1'b0, 1'b1, 1'b1, 32'h40, 32'h0, 5'd9, 0, 0, 1'b1);
        chk("tmo_exc", {30'b0, ExcW}, 32'h2);
        chk("tmo_stall", last_stall, 10);

        // Reset while waiting in RSP0; a late response must be ignored.
        strCtrlM = 3'b010; MemWriteM = 1'b0; MemtoRegM = 1'b1; RegWriteM = 1'b1;
        ALUoutM = 32'h80; rdM = 5'd9;
        seen = 0;
        for (int cyc = 0; cyc < 10 && !seen; cyc++) begin
            @(negedge clk);
            dmem_gnt = 1'b0;
            if (dmem_req) begin dmem_gnt = 1'b1; seen = 1; end
            @(posedge clk);
        end
        #1 dmem_gnt = 1'b0;
        chk("rstmid_granted", {31'b0, seen}, 32'd1);
        @(negedge clk);
        chk("rstmid_stall_rsp0", {31'b0, stallM}, 32'd1);
        rst = 1'b1;
        set_nop();
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rstmid_stallM", {31'b0, stallM}, 32'd0);
        chk("rstmid_req", {31'b0, dmem_req}, 32'd0);
        chk("rstmid_W", {27'b0, rdW} | {31'b0, RegWriteW} | {30'b0, ExcW} | ALUoutW, 32'd0);
        @(negedge clk);
        dmem_rvalid = 1'b1; dmem_rdata = 32'hCAFEF00D;
        @(posedge clk); #1;
        dmem_rvalid = 1'b0;
        chk("late_rvalid_stall", {31'b0, stallM}, 32'd0);
        chk("late_rvalid_req", {31'b0, dmem_req}, 32'd0);
        chk("late_rvalid_regwrite", {31'b0, RegWriteW}, 32'd0);
        chk("late_rvalid_readdata", ReadDataW, 32'd0);
        chk("late_rvalid_exc", {30'b0, ExcW}, 32'd0);

        // Randomized mix of non-memory ops, loads and stores, including wrap-around.
        for (int t = 0; t < 80; t++) begin
            kind = int'($urandom_range(0, 2));
            ra = ($urandom_range(0, 1) == 1 ? 32'h0000_1000 : 32'hFFFF_FFF0) + 32'($urandom_range(0, 15));
            case (kind)
                0: run_op(3'($urandom_range(0, 7)), 1'b0, 1'b0, 1'($urandom_range(0, 1)),
                          $urandom, $urandom, 5'($urandom_range(0, 31)), -1, -1, 1'b0);
                1: run_op(ld_f3[$urandom_range(0, 4)], 1'b0, 1'b1, 1'($urandom_range(0, 1)),
                          ra, $urandom, 5'($urandom_range(0, 31)), -1, -1, 1'b0);
                default: run_op(3'($urandom_range(0, 2)), 1'b1, 1'b0, 1'($urandom_range(0, 1)),
                          ra, $urandom, 5'($urandom_range(0, 31)), -1, -1, 1'b0);
            endcase
        end

        // Flag-only instance: misaligned accesses never reach the bus.
        rst = 1'b1;
        set_nop();
        @(posedge clk); #1;
        rst2 = 1'b0;
        run_ns(3'b001, 1'b0, 1'b1, 32'h3, st, rq);
        chk("ns_lh_stall", st, 1);
        chk("ns_lh_reqs", rq, 0);
        chk("ns_lh_exc", {30'b0, ns_ExcW}, 32'h1);
        chk("ns_lh_regwrite", {31'b0, ns_RegWriteW}, 32'd0);
        run_ns(3'b010, 1'b1, 1'b0, 32'h1, st, rq);
        chk("ns_sw_reqs", rq, 0);
        chk("ns_sw_exc", {30'b0, ns_ExcW}, 32'h1);
        run_ns(3'b010, 1'b0, 1'b1, 32'h8, st, rq);
        chk("ns_lw_stall", st, 3);
        chk("ns_lw_value", ns_ReadDataW, 32'hDEADBEEF);
        chk("ns_lw_exc", {30'b0, ns_ExcW}, 32'h0);
        chk("ns_lw_regwrite", {31'b0, ns_RegWriteW}, 32'd1);
        run_ns(3'b000, 1'b0, 1'b1, 32'h3, st, rq);
        chk("ns_lb_value", ns_ReadDataW, 32'hFFFFFFDE);
        chk("ns_lb_exc", {30'b0, ns_ExcW}, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
